// File: rtl/lector_salidas_pkg.sv
// Shared definitions for the output-FIFO drain reader: word layout and FSM encoding.
package lector_salidas_pkg;

  localparam int WORD_SIZE = 10;
  localparam int NUM_PORTS = 4;

  // Destination field occupies the top DEST_W bits of every word
  localparam int DEST_W   = 2;
  localparam int DEST_MSB = WORD_SIZE - 1;
  localparam int DEST_LSB = WORD_SIZE - DEST_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/rr_sel4.sv
// Four-way round-robin grant: the search starts at last_port+1 and wraps.
module rr_sel4 (
  input  logic [3:0] req,
  input  logic [1:0] last_port,
  output logic [1:0] grant,
  output logic       any_req
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = last_port;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_port + 2'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/lector_salidas.sv
// Drains four output FIFOs round-robin onto one valid/ready stream, tagging the
// source port, counting delivered words per port and flagging destination mismatches.
module lector_salidas
  import lector_salidas_pkg::*;
#(
  parameter int FIFO_WORD_SIZE = WORD_SIZE,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      empty_p0,
  input  logic                      empty_p1,
  input  logic                      empty_p2,
  input  logic                      empty_p3,
  input  logic [FIFO_WORD_SIZE-1:0] data_in_0,
  input  logic [FIFO_WORD_SIZE-1:0] data_in_1,
  input  logic [FIFO_WORD_SIZE-1:0] data_in_2,
  input  logic [FIFO_WORD_SIZE-1:0] data_in_3,
  output logic                      pop_p0,
  output logic                      pop_p1,
  output logic                      pop_p2,
  output logic                      pop_p3,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [1:0]                port_out,
  output logic [CNT_WIDTH-1:0]      count_p0,
  output logic [CNT_WIDTH-1:0]      count_p1,
  output logic [CNT_WIDTH-1:0]      count_p2,
  output logic [CNT_WIDTH-1:0]      count_p3,
  output logic                      dest_err
);

  localparam int DMSB = FIFO_WORD_SIZE - 1;
  localparam int DLSB = FIFO_WORD_SIZE - DEST_W;

  state_t                    state_reg, state_next;
  logic [1:0]                last_port_reg;
  logic [1:0]                grant_reg;
  logic [FIFO_WORD_SIZE-1:0] data_out_reg;
  logic [1:0]                port_out_reg;
  logic                      dest_err_reg;
  logic [CNT_WIDTH-1:0]      count_reg [NUM_PORTS];

  logic [3:0]                req;
  logic [1:0]                grant;
  logic                      any_req;
  logic                      issue_pop;
  logic                      deliver;
  logic [3:0]                pop_vec;
  logic [FIFO_WORD_SIZE-1:0] data_in_arr [NUM_PORTS];
  logic [FIFO_WORD_SIZE-1:0] captured;

  assign req = ~{empty_p3, empty_p2, empty_p1, empty_p0};

  assign data_in_arr[0] = data_in_0;
  assign data_in_arr[1] = data_in_1;
  assign data_in_arr[2] = data_in_2;
  assign data_in_arr[3] = data_in_3;

  rr_sel4 u_rr_sel4 (
    .req       (req),
    .last_port (last_port_reg),
    .grant     (grant),
    .any_req   (any_req)
  );

  // FIFO read data is only valid in READ, for the port popped the cycle before
  assign captured = data_in_arr[grant_reg];
  assign deliver  = (state_reg == ST_SEND) && ready_in;

  always_comb begin
    state_next = state_reg;
    issue_pop  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          issue_pop  = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (ready_in) begin
          if (any_req) begin
            issue_pop  = 1'b1;
            state_next = ST_READ;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pops are combinational and must never fire while reset is held
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_pop
      assign pop_vec[gi] = issue_pop && !reset && (grant == 2'(gi));
    end
  endgenerate

  assign pop_p0 = pop_vec[0];
  assign pop_p1 = pop_vec[1];
  assign pop_p2 = pop_vec[2];
  assign pop_p3 = pop_vec[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      last_port_reg <= 2'd3;
      grant_reg     <= 2'd0;
      data_out_reg  <= '0;
      port_out_reg  <= 2'd0;
      dest_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (issue_pop) begin
        grant_reg <= grant;
      end
      if (state_reg == ST_READ) begin
        data_out_reg  <= captured;
        port_out_reg  <= grant_reg;
        last_port_reg <= grant_reg;
        if (captured[DMSB:DLSB] != grant_reg) begin
          dest_err_reg <= 1'b1;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg[gi] <= '0;
        end else if (deliver && (port_out_reg == 2'(gi))) begin
          count_reg[gi] <= count_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign data_out  = data_out_reg;
  assign valid_out = (state_reg == ST_SEND);
  assign port_out  = port_out_reg;
  assign dest_err  = dest_err_reg;
  assign count_p0  = count_reg[0];
  assign count_p1  = count_reg[1];
  assign count_p2  = count_reg[2];
  assign count_p3  = count_reg[3];

endmodule

// File: tb/tb_lector_salidas.sv
// Scoreboard bench for lector_salidas: FIFO models feed the DUT, expected words and pop order are queued at stimulus time.
module tb_lector_salidas;

  localparam int W  = 10;
  localparam int CW = 2;

  typedef struct packed {
    logic [1:0]   port;
    logic [W-1:0] word;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready_in = 1'b0;
  logic [3:0]    empty_vec;
  logic [3:0]    pop_vec;
  logic [W-1:0]  data_in [4] = '{default: '0};
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic [1:0]    port_out;
  logic [CW-1:0] cnt_out [4];
  logic          dest_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] mem [4][64];
  int push_cnt [4] = '{default: 0};
  int pop_cnt  [4] = '{default: 0};

  exp_t       sb[$];
  logic [1:0] pop_exp[$];
  int         pop_cyc[$];
  int         cnt_model [4] = '{default: 0};
  bit         chk_cnt = 1'b0;

  always #5 clk = ~clk;

  lector_salidas #(.FIFO_WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty_p0  (empty_vec[0]),
    .empty_p1  (empty_vec[1]),
    .empty_p2  (empty_vec[2]),
    .empty_p3  (empty_vec[3]),
    .data_in_0 (data_in[0]),
    .data_in_1 (data_in[1]),
    .data_in_2 (data_in[2]),
    .data_in_3 (data_in[3]),
    .pop_p0    (pop_vec[0]),
    .pop_p1    (pop_vec[1]),
    .pop_p2    (pop_vec[2]),
    .pop_p3    (pop_vec[3]),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .port_out  (port_out),
    .count_p0  (cnt_out[0]),
    .count_p1  (cnt_out[1]),
    .count_p2  (cnt_out[2]),
    .count_p3  (cnt_out[3]),
    .dest_err  (dest_err)
  );

  // FIFO models: registered read data, one cycle after the pop
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      assign empty_vec[gi] = (push_cnt[gi] == pop_cnt[gi]);
    end
  endgenerate

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < 4; p++) begin
      if (pop_vec[p] && (push_cnt[p] != pop_cnt[p])) begin
        data_in[p] <= mem[p][pop_cnt[p] % 64];
        pop_cnt[p] <= pop_cnt[p] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input int p, input logic [W-1:0] w);
    exp_t e;
    mem[p][push_cnt[p] % 64] = w;
    push_cnt[p]++;
    e.port = 2'(p);
    e.word = w;
    sb.push_back(e);
    pop_exp.push_back(2'(p));
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!valid_out && n < limit);
    chk("wait_valid", 32'(valid_out), 32'd1);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || pop_exp.size() != 0 || valid_out) && n < limit) begin
      @(negedge clk); #2;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (2) begin
      @(negedge clk); #2;
    end
  endtask

  // Monitor: pops and handshakes are sampled mid-cycle, counters one cycle later
  always begin
    @(negedge clk); #1;
    if (reset) begin
      chk_cnt = 1'b0;
    end else begin
      if (chk_cnt) begin
        for (int p = 0; p < 4; p++) chk($sformatf("count_p%0d", p), 32'(cnt_out[p]), 32'(cnt_model[p]));
        chk_cnt = 1'b0;
      end
      if (pop_vec != 4'b0) begin
        int idx;
        idx = 0;
        for (int p = 0; p < 4; p++) if (pop_vec[p]) idx = p;
        chk("pop_onehot", 32'($onehot(pop_vec)), 32'd1);
        if (pop_exp.size() > 0) begin
          chk("pop_order", 32'(idx), 32'(pop_exp.pop_front()));
          pop_cyc.push_back(cyc);
        end else begin
          chk("pop_unexpected", 32'(pop_vec), 32'd0);
        end
      end
      if (valid_out && ready_in) begin
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.word));
          chk("port_out", 32'(port_out), 32'(e.port));
          $display("deliver port=%0d word=%03h", port_out, data_out);
          cnt_model[e.port] = (cnt_model[e.port] + 1) % (1 << CW);
          chk_cnt = 1'b1;
        end else begin
          chk("delivery_unexpected", 32'(data_out), 32'hFFFF_FFFF);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every FIFO non-empty
    reset = 1'b1;
    ready_in = 1'b1;
    push_word(0, 10'h011);
    push_word(1, 10'h122);
    push_word(2, 10'h233);
    push_word(3, 10'h344);
    push_word(0, 10'h055);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pop", 32'(pop_vec), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_port", 32'(port_out), 32'd0);
    chk("rst_dest_err", 32'(dest_err), 32'd0);
    for (int p = 0; p < 4; p++) chk("rst_count", 32'(cnt_out[p]), 32'd0);

    // Release: p0 first, two-edge latency, then round-robin
    @(negedge clk);
    reset = 1'b0;
    pop_cyc.delete();
    #2;
    chk("first_pop_p0", 32'(pop_vec), 32'b0001);
    @(negedge clk); #2;
    chk("read_no_valid", 32'(valid_out), 32'd0);
    chk("read_no_pop", 32'(pop_vec), 32'd0);
    @(negedge clk); #2;
    chk("first_valid", 32'(valid_out), 32'd1);
    chk("first_data", 32'(data_out), 32'h011);
    wait_drain(200);
    if (pop_cyc.size() >= 5) chk("rr_throughput", 32'(pop_cyc[4] - pop_cyc[0]), 32'd8);
    else chk("rr_pop_count", 32'(pop_cyc.size()), 32'd5);
    chk("rr_count_p1", 32'(cnt_out[1]), 32'd1);
    chk("rr_count_p3", 32'(cnt_out[3]), 32'd1);

    // Backpressure: word held while ready_in is low, no pop until accepted
    @(negedge clk);
    ready_in = 1'b0;
    push_word(0, 10'h0C5);
    wait_valid(20);
    push_word(1, 10'h1A0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(valid_out), 32'd1);
      chk("bp_data", 32'(data_out), 32'h0C5);
      chk("bp_no_pop", 32'(pop_vec), 32'd0);
      @(negedge clk); #2;
    end
    @(negedge clk);
    ready_in = 1'b1;
    #2;
    chk("bp_pop_after_accept", 32'(pop_vec), 32'b0010);
    wait_drain(200);
    chk("bp_count_p0", 32'(cnt_out[0]), 32'd3);

    // Destination mismatch: sticky from the capture edge, word still delivered
    chk("dest_err_clear", 32'(dest_err), 32'd0);
    @(negedge clk);
    push_word(2, 10'h1AB);
    #2;
    chk("dest_pop_p2", 32'(pop_vec), 32'b0100);
    @(negedge clk); #2;
    chk("dest_err_pre", 32'(dest_err), 32'd0);
    @(negedge clk); #2;
    chk("dest_err_set", 32'(dest_err), 32'd1);
    chk("dest_port", 32'(port_out), 32'd2);
    wait_drain(200);
    chk("dest_err_sticky", 32'(dest_err), 32'd1);

    // Reset in SEND: valid_out drops without a clock edge
    @(negedge clk);
    ready_in = 1'b0;
    push_word(3, 10'h3CC);
    wait_valid(20);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_dest_err", 32'(dest_err), 32'd0);
    chk("midrst_count_p0", 32'(cnt_out[0]), 32'd0);
    sb.delete();
    pop_exp.delete();
    for (int p = 0; p < 4; p++) cnt_model[p] = 0;
    push_word(0, 10'h0D1);
    push_word(1, 10'h1E2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ready_in = 1'b1;
    #2;
    chk("restart_p0", 32'(pop_vec), 32'b0001);
    wait_drain(200);

    // Counter wrap on p3 only: 1,2,3,0,1
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push_word(3, 10'h300 + 10'(i));
    wait_drain(200);
    chk("wrap_count_p3", 32'(cnt_out[3]), 32'd1);
    chk("wrap_count_p2", 32'(cnt_out[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
